// File: rtl/transfer_scheduler_pkg.sv
// Shared definitions for the gondola transfer link: command codes, FSM states and
// the payload length agreed with the transfer station.
package transfer_scheduler_pkg;

  localparam logic [7:0] CMD_50     = 8'd1;
  localparam logic [7:0] CMD_80     = 8'd2;
  localparam logic [7:0] CMD_90     = 8'd3;
  localparam logic [7:0] CMD_100    = 8'd4;
  localparam logic [7:0] CMD_STREAM = 8'd7;

  localparam int unsigned PAYLOAD_BYTES_DEFAULT = 128;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StShiftLo,
    StShiftHi,
    StFetch,
    StLoad,
    StFinish,
    StGap
  } state_e;

  function automatic logic cmd_valid(input logic [7:0] cmd);
    return (cmd == CMD_50) || (cmd == CMD_80) || (cmd == CMD_90) ||
           (cmd == CMD_100) || (cmd == CMD_STREAM);
  endfunction

endpackage

// File: rtl/transfer_scheduler_if.sv
// Requester and station signals of the transfer scheduler, grouped as one bundle.
interface transfer_scheduler_if;
  logic       transfer_ready;
  logic       transfer_data;
  logic       transfer_clock;
  logic [1:0] req;
  logic [7:0] cmd0;
  logic [7:0] cmd1;
  logic [7:0] pay_data0;
  logic [7:0] pay_data1;
  logic [1:0] grant;
  logic       pay_rd;
  logic       done;
  logic       err;
  logic       busy;

  modport master (
    input  transfer_ready, req, cmd0, cmd1, pay_data0, pay_data1,
    output transfer_data, transfer_clock, grant, pay_rd, done, err, busy
  );

  modport slave (
    output transfer_ready, req, cmd0, cmd1, pay_data0, pay_data1,
    input  transfer_data, transfer_clock, grant, pay_rd, done, err, busy
  );
endinterface

// File: rtl/transfer_bit_serializer.sv
// MSB-first byte serializer: shift register, phase counter and ready-gated serial clock.
// The serial clock comes straight from a flop so the station never sees decode glitches.
module transfer_bit_serializer #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       clear,
  input  logic       active,
  input  logic       ready,
  input  logic [7:0] load_byte,
  output logic       sdata,
  output logic       sclk,
  output logic       rise,
  output logic       bit_end,
  output logic       byte_done
);

  localparam int unsigned CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [7:0]    shreg_q;
  logic [CW-1:0] phase_q;
  logic [2:0]    bit_q;
  logic          hi_q;
  logic          term;

  assign term      = (phase_q == TERM);
  assign rise      = active & ~hi_q & term & ready;
  assign bit_end   = active & hi_q & term;
  assign byte_done = bit_end & (bit_q == 3'd7);
  assign sdata     = shreg_q[7];
  assign sclk      = hi_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      phase_q <= '0;
      bit_q   <= '0;
      hi_q    <= 1'b0;
    end else if (clear) begin
      shreg_q <= '0;
      phase_q <= '0;
      bit_q   <= '0;
      hi_q    <= 1'b0;
    end else if (load) begin
      shreg_q <= load_byte;
      phase_q <= '0;
      bit_q   <= '0;
      hi_q    <= 1'b0;
    end else if (active) begin
      if (rise) begin
        hi_q    <= 1'b1;
        phase_q <= '0;
      end else if (bit_end) begin
        hi_q    <= 1'b0;
        phase_q <= '0;
        shreg_q <= {shreg_q[6:0], 1'b0};
        bit_q   <= bit_q + 3'd1;
      end else if (!term) begin
        // Low phase parks at terminal count while the station is not ready.
        phase_q <= phase_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/transfer_scheduler.sv
// Master side of the gondola transfer link: round-robin arbiter plus command/payload FSM
// driving the bit serializer.
module transfer_scheduler
  import transfer_scheduler_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned PAYLOAD_BYTES = PAYLOAD_BYTES_DEFAULT,
  parameter int unsigned GAP_CYCLES    = 8
) (
  input logic                  clk,
  input logic                  rst,
  transfer_scheduler_if.master bus
);

  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  state_e        state_q, state_d;
  logic [1:0]    grant_q, grant_d, pick;
  logic          ptr_q, ptr_d;
  logic [7:0]    bytes_q, bytes_d;
  logic [7:0]    cmd_q, cmd_d, sel_cmd, load_byte;
  logic [GW-1:0] gap_q, gap_d;
  logic          load, clear, active, rise, bit_end, byte_done;
  logic          pay_rd, done, err;

  // ptr_q remembers the requester served last; a tie goes to the other one.
  always_comb begin
    if (bus.req == 2'b11) begin
      pick = ptr_q ? 2'b01 : 2'b10;
    end else begin
      pick = bus.req;
    end
    sel_cmd = pick[1] ? bus.cmd1 : bus.cmd0;
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    bytes_d   = bytes_q;
    cmd_d     = cmd_q;
    gap_d     = gap_q;
    load      = 1'b0;
    clear     = 1'b0;
    load_byte = sel_cmd;
    pay_rd    = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|bus.req) begin
          grant_d = pick;
          cmd_d   = sel_cmd;
          load    = 1'b1;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (cmd_valid(cmd_q)) begin
          bytes_d = '0;
          state_d = StShiftLo;
        end else begin
          err     = 1'b1;
          clear   = 1'b1;
          grant_d = '0;
          ptr_d   = grant_q[1];
          gap_d   = '0;
          state_d = StGap;
        end
      end
      StShiftLo: begin
        if (rise) state_d = StShiftHi;
      end
      StShiftHi: begin
        if (byte_done) begin
          if (cmd_q == CMD_STREAM && bytes_q < 8'(PAYLOAD_BYTES)) begin
            state_d = StFetch;
          end else begin
            state_d = StFinish;
          end
        end else if (bit_end) begin
          state_d = StShiftLo;
        end
      end
      StFetch: begin
        pay_rd  = 1'b1;
        state_d = StLoad;
      end
      StLoad: begin
        load      = 1'b1;
        load_byte = grant_q[1] ? bus.pay_data1 : bus.pay_data0;
        bytes_d   = bytes_q + 8'd1;
        state_d   = StShiftLo;
      end
      StFinish: begin
        done    = 1'b1;
        grant_d = '0;
        ptr_d   = grant_q[1];
        gap_d   = '0;
        state_d = StGap;
      end
      StGap: begin
        if (gap_q == GAP_LAST) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= 1'b1;
      bytes_q <= '0;
      cmd_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      bytes_q <= bytes_d;
      cmd_q   <= cmd_d;
      gap_q   <= gap_d;
    end
  end

  assign active = (state_q == StShiftLo) || (state_q == StShiftHi);

  transfer_bit_serializer #(
    .CLK_DIV(CLK_DIV)
  ) u_serializer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .clear    (clear),
    .active   (active),
    .ready    (bus.transfer_ready),
    .load_byte(load_byte),
    .sdata    (bus.transfer_data),
    .sclk     (bus.transfer_clock),
    .rise     (rise),
    .bit_end  (bit_end),
    .byte_done(byte_done)
  );

  // Grant shows up in the arbitration cycle itself and is held by grant_q afterwards.
  assign bus.grant  = rst ? 2'b00 : ((state_q == StIdle) ? pick : grant_q);
  assign bus.busy   = (state_q != StIdle);
  assign bus.pay_rd = pay_rd;
  assign bus.done   = done;
  assign bus.err    = err;

endmodule

// File: tb/tb_transfer_scheduler.sv
// Directed bench for transfer_scheduler: station-side bit capture, payload responder and
// per-scenario checks.
module tb_transfer_scheduler;

  localparam int CD  = 2;
  localparam int PB  = 128;
  localparam int GAP = 8;

  logic clk = 1'b0;
  logic rst;

  transfer_scheduler_if bus ();

  transfer_scheduler #(
    .CLK_DIV      (CD),
    .PAYLOAD_BYTES(PB),
    .GAP_CYCLES   (GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors, checks;
  int cyc, rises, pay_rds, dones, errs, both_grant;
  int rise_cyc_last, grant_rise_cyc, done_cyc, err_cyc, pay_start;
  logic [1:0] grant_at_done, prev_grant;
  logic       prev_sclk;
  logic [7:0] acc;
  int         accn;
  logic [7:0] rx[$];

  // Station model: capture a bit on each serial clock rise, serve payload on pay_rd.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      accn = 0;
      prev_sclk = 1'b0;
      prev_grant = 2'b00;
    end else begin
      if (bus.transfer_clock && !prev_sclk) begin
        rises++;
        rise_cyc_last = cyc;
        acc = {acc[6:0], bus.transfer_data};
        accn++;
        if (accn == 8) begin
          rx.push_back(acc);
          accn = 0;
        end
      end
      if (bus.pay_rd) begin
        bus.pay_data1 = 8'(pay_rds - pay_start);
        pay_rds++;
      end
      if (bus.done) begin
        dones++;
        done_cyc = cyc;
        grant_at_done = bus.grant;
      end
      if (bus.err) begin
        errs++;
        err_cyc = cyc;
      end
      if (bus.grant == 2'b11) both_grant++;
      if (bus.grant != 2'b00 && prev_grant == 2'b00) grant_rise_cyc = cyc;
      prev_sclk = bus.transfer_clock;
      prev_grant = bus.grant;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [1:0] v);
    @(posedge clk);
    #1;
    bus.req = v;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0 = dones;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (dones != d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_err(input int budget, output bit ok);
    int e0 = errs;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (errs != e0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [7:0] outv();
    return {bus.transfer_clock, bus.transfer_data, bus.grant, bus.pay_rd, bus.done, bus.err,
            bus.busy};
  endfunction

  function automatic logic [7:0] rx_at(input int idx);
    logic [7:0] v = 8'hxx;
    if (idx < rx.size()) v = rx[idx];
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (outv() !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000000", outv());
    end
    bus.req = 2'b01;
    tick();
    checks++;
    if (bus.grant !== 2'b00 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_holds_grant: got grant=%b busy=%b want 00/0", bus.grant, bus.busy);
    end
    bus.req = 2'b00;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_single();
    int r0 = rises;
    int n0 = rx.size();
    bit ok, ok_i;
    bus.cmd0 = 8'd2;
    drive_req(2'b01);
    wait_done(200, ok);
    bus.req = 2'b00;
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL single_done: got timeout want done"); end
    checks++;
    if (grant_at_done !== 2'b01) begin
      errors++; $display("FAIL single_grant: got %b want 01", grant_at_done);
    end
    checks++;
    if (done_cyc - grant_rise_cyc !== 34) begin
      errors++; $display("FAIL single_latency: got %0d want 34", done_cyc - grant_rise_cyc);
    end
    checks++;
    if (rises - r0 !== 8) begin
      errors++; $display("FAIL single_edges: got %0d want 8", rises - r0);
    end
    checks++;
    if (rise_cyc_last - grant_rise_cyc !== 32) begin
      errors++;
      $display("FAIL single_last_edge: got %0d want 32", rise_cyc_last - grant_rise_cyc);
    end
    checks++;
    if (rx_at(n0) !== 8'h02) begin
      errors++; $display("FAIL single_byte: got %h want 02", rx_at(n0));
    end
    wait_idle(ok_i);
    checks++;
    if (ok_i !== 1'b1) begin errors++; $display("FAIL single_idle: got busy want idle"); end
  endtask

  task automatic test_stream();
    int r0 = rises;
    int n0 = rx.size();
    int p0 = pay_rds;
    int d0 = dones;
    int bad = 0;
    bit ok, ok_i;
    pay_start = pay_rds;
    bus.cmd1 = 8'd7;
    drive_req(2'b10);
    wait_done(6000, ok);
    bus.req = 2'b00;
    wait_idle(ok_i);
    repeat (4) tick();
    checks++;
    if ({ok, ok_i} !== 2'b11) begin
      errors++; $display("FAIL stream_done: got %b want 11", {ok, ok_i});
    end
    checks++;
    if (pay_rds - p0 !== 128) begin
      errors++; $display("FAIL stream_pay_rd: got %0d want 128", pay_rds - p0);
    end
    checks++;
    if (rises - r0 !== 1032) begin
      errors++; $display("FAIL stream_edges: got %0d want 1032", rises - r0);
    end
    checks++;
    if (dones - d0 !== 1) begin
      errors++; $display("FAIL stream_done_count: got %0d want 1", dones - d0);
    end
    checks++;
    if (grant_at_done !== 2'b10) begin
      errors++; $display("FAIL stream_grant: got %b want 10", grant_at_done);
    end
    checks++;
    if (rx.size() - n0 !== 129 || rx_at(n0) !== 8'h07) begin
      errors++;
      $display("FAIL stream_header: got %0d bytes first=%h want 129 bytes first=07",
               rx.size() - n0, rx_at(n0));
    end
    for (int i = 1; i < 129; i++) begin
      if (rx_at(n0 + i) !== 8'(i - 1)) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL stream_payload: got %0d wrong bytes want 0", bad);
    end
  endtask

  task automatic test_tie();
    int n0 = rx.size();
    bit ok1, ok2, ok3, oki;
    logic [1:0] g1, g2, g3;
    bus.cmd0 = 8'd1;
    bus.cmd1 = 8'd3;
    drive_req(2'b11);
    wait_done(200, ok1);
    g1 = grant_at_done;
    wait_done(200, ok2);
    g2 = grant_at_done;
    bus.req = 2'b00;
    wait_idle(oki);
    drive_req(2'b11);
    wait_done(200, ok3);
    g3 = grant_at_done;
    bus.req = 2'b00;
    wait_idle(oki);
    checks++;
    if ({ok1, ok2, ok3} !== 3'b111) begin
      errors++; $display("FAIL tie_done: got %b want 111", {ok1, ok2, ok3});
    end
    checks++;
    if ({g1, g2, g3} !== 6'b01_10_01) begin
      errors++; $display("FAIL tie_order: got %b want 011001", {g1, g2, g3});
    end
    checks++;
    if ({rx_at(n0), rx_at(n0 + 1), rx_at(n0 + 2)} !== 24'h01_03_01) begin
      errors++;
      $display("FAIL tie_bytes: got %h %h %h want 01 03 01", rx_at(n0), rx_at(n0 + 1),
               rx_at(n0 + 2));
    end
  endtask

  task automatic test_ready_stall();
    int r0 = rises;
    int n0 = rx.size();
    int highs = 0;
    bit found = 1'b0;
    bit ok, oki;
    bus.cmd0 = 8'd3;
    drive_req(2'b01);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (rises - r0 == 3 && !bus.transfer_clock) begin
        found = 1'b1;
        break;
      end
    end
    bus.transfer_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.transfer_clock) highs++;
    end
    checks++;
    if (found !== 1'b1 || highs !== 0 || rises - r0 !== 3) begin
      errors++;
      $display("FAIL stall_hold: got found=%b highs=%0d edges=%0d want 1 0 3", found, highs,
               rises - r0);
    end
    bus.transfer_ready = 1'b1;
    wait_done(200, ok);
    bus.req = 2'b00;
    checks++;
    if (ok !== 1'b1 || rises - r0 !== 8) begin
      errors++; $display("FAIL stall_edges: got ok=%b edges=%0d want 1 8", ok, rises - r0);
    end
    checks++;
    if (rx_at(n0) !== 8'h03) begin
      errors++; $display("FAIL stall_byte: got %h want 03", rx_at(n0));
    end
    wait_idle(oki);
  endtask

  task automatic test_err();
    int r0 = rises;
    int n0 = rx.size();
    bit ok, ok2, oki;
    bit seen = 1'b0;
    logic [1:0] gerr, g1;
    logic b1;
    bus.cmd0 = 8'd5;
    drive_req(2'b01);
    wait_err(50, ok);
    gerr = bus.grant;
    bus.req = 2'b00;
    bus.cmd0 = 8'd4;
    tick();
    b1 = bus.busy;
    g1 = bus.grant;
    bus.req = 2'b01;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.grant != 2'b00) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (ok !== 1'b1 || gerr !== 2'b01) begin
      errors++; $display("FAIL err_pulse: got ok=%b grant=%b want 1 01", ok, gerr);
    end
    checks++;
    if ({b1, g1} !== 3'b1_00) begin
      errors++; $display("FAIL err_gap_state: got busy=%b grant=%b want 1 00", b1, g1);
    end
    checks++;
    if (seen !== 1'b1 || grant_rise_cyc - err_cyc !== GAP + 1) begin
      errors++;
      $display("FAIL err_gap_len: got seen=%b gap=%0d want 1 %0d", seen,
               grant_rise_cyc - err_cyc, GAP + 1);
    end
    checks++;
    if (rises - r0 !== 0) begin
      errors++; $display("FAIL err_no_clock: got %0d edges want 0", rises - r0);
    end
    wait_done(200, ok2);
    bus.req = 2'b00;
    checks++;
    if (ok2 !== 1'b1 || rx_at(n0) !== 8'h04) begin
      errors++; $display("FAIL err_next: got ok=%b byte=%h want 1 04", ok2, rx_at(n0));
    end
    wait_idle(oki);
  endtask

  task automatic test_reset_midstream();
    int p0 = pay_rds;
    int r0, n0;
    bit found = 1'b0;
    bit ok, oki;
    logic [7:0] v1, v2;
    pay_start = pay_rds;
    bus.cmd1 = 8'd7;
    drive_req(2'b10);
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (pay_rds - p0 >= 40) begin
        found = 1'b1;
        break;
      end
    end
    #2;
    rst = 1'b1;
    #1;
    v1 = outv();
    @(posedge clk);
    @(posedge clk);
    #1;
    v2 = outv();
    checks++;
    if (found !== 1'b1 || v1 !== 8'h00) begin
      errors++; $display("FAIL rst_async: got found=%b outs=%b want 1 00000000", found, v1);
    end
    checks++;
    if (v2 !== 8'h00) begin
      errors++; $display("FAIL rst_hold: got %b want 00000000", v2);
    end
    bus.req = 2'b00;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.grant !== 2'b00) begin
      errors++;
      $display("FAIL rst_idle: got busy=%b grant=%b want 0 00", bus.busy, bus.grant);
    end
    r0 = rises;
    n0 = rx.size();
    bus.cmd0 = 8'd4;
    bus.cmd1 = 8'd2;
    drive_req(2'b11);
    wait_done(200, ok);
    bus.req = 2'b00;
    checks++;
    if (ok !== 1'b1 || grant_at_done !== 2'b01) begin
      errors++;
      $display("FAIL rst_pointer: got ok=%b grant=%b want 1 01", ok, grant_at_done);
    end
    checks++;
    if (rx_at(n0) !== 8'h04 || rises - r0 !== 8) begin
      errors++;
      $display("FAIL rst_fresh: got byte=%h edges=%0d want 04 8", rx_at(n0), rises - r0);
    end
    wait_idle(oki);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.req = 2'b00;
    bus.cmd0 = 8'd0;
    bus.cmd1 = 8'd0;
    bus.pay_data0 = 8'd0;
    bus.transfer_ready = 1'b1;
    test_reset();
    test_single();
    test_stream();
    test_tie();
    test_ready_stall();
    test_err();
    test_reset_midstream();
    checks++;
    if (both_grant !== 0) begin
      errors++; $display("FAIL grant_onehot: got %0d double grants want 0", both_grant);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/transfer_scheduler.md
Name: transfer_scheduler

Overview:
- Master side of the gondola transfer link.
- Arbitrates between two requesters and serialises each granted command byte, MSB first, onto transfer_data/transfer_clock for the transfer station.
- A stream command (value 7) is followed by the PAYLOAD_BYTES payload bytes fetched from the granted requester.
- Transmission only advances while the station reports transfer_ready.

Parameters:
CLK_DIV, 4, clk cycles per transfer_clock phase (low and high each); bit period = 2*CLK_DIV; minimum 1
PAYLOAD_BYTES, 128, payload bytes sent after command 7; range 1..255
GAP_CYCLES, 8, idle clk cycles enforced between transactions

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock, asynchronous and active-high
transfer_ready  in  1  station ready/active
transfer_data  out  1  serial data to station
transfer_clock  out  1  serial clock to station; station samples on its rising edge
req  in  2  per-requester request level, held until done/err
cmd0  in  8  requester 0 command, stable while req[0]
cmd1  in  8  requester 1 command, stable while req[1]
pay_data0  in  8  requester 0 payload byte
pay_data1  in  8  requester 1 payload byte
grant  out  2  one-hot grant, held for the whole transaction
pay_rd  out  1  one-cycle pulse: granted requester presents the next byte on its pay_data the following cycle
done  out  1  one-cycle pulse: transaction completed
err  out  1  one-cycle pulse: command rejected
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, any time including mid-payload) forces all outputs to 0 (transfer_clock low) and state to IDLE. Byte and bit counters clear. Round-robin pointer resets so requester 0 wins the first tie.
- States: IDLE, CHECK, SHIFT_LO, SHIFT_HI, FETCH, LOAD, FINISH, GAP.
- IDLE:
  - If any req bit is set, grant the single requester; on a tie, grant the one not served last.
  - Next cycle enter CHECK with grant asserted and the granted cmd latched into an 8-bit shift register.
- CHECK:
  - cmd in {1,2,3,4,7} is valid: bit count = 0, go to SHIFT_LO.
  - Any other value: pulse err, drop grant, update the pointer, go to GAP. No transfer_clock edge is produced.
- SHIFT_LO:
  - transfer_data = shreg[7], transfer_clock = 0.
  - Phase counter runs CLK_DIV cycles.
  - At terminal count, move to SHIFT_HI only if transfer_ready = 1. Otherwise hold SHIFT_LO with the counter frozen at terminal count; rise on the first cycle ready returns.
- SHIFT_HI:
  - transfer_clock = 1 for CLK_DIV cycles; it always completes even if ready drops. transfer_data is unchanged.
  - At the end: shift shreg left and increment the bit count.
  - If bits < 8, go to SHIFT_LO.
  - Else if cmd = 7 and bytes sent < PAYLOAD_BYTES, go to FETCH.
  - Else go to FINISH.
- FETCH: pay_rd = 1 for one cycle, then LOAD.
- LOAD: shreg <= pay_data of the granted requester, bit count = 0, bytes sent + 1, then SHIFT_LO.
  - Inter-byte spacing is exactly 2 clk (FETCH + LOAD) added to the low phase.
- FINISH: done = 1 for one cycle, grant cleared, pointer updated, go to GAP.
- GAP: GAP_CYCLES cycles with transfer_clock low, then IDLE.
  - A request still high in IDLE is treated as a new transaction.
- Timing:
  - Bit period is 2*CLK_DIV with ready held high.
  - Single-byte transaction: grant to done = 2 + 16*CLK_DIV cycles.
- Widths: the byte counter is 8 bits. The phase counter is $clog2(CLK_DIV+1) bits.
- Deassertion of req mid-transaction is ignored; the transaction completes.

Decomposition:
- Shared package holds:
  - command constants CMD_50=1, CMD_80=2, CMD_90=3, CMD_100=4, CMD_STREAM=7;
  - the state enum;
  - PAYLOAD_BYTES default shared with the station.
- One sub-module, transfer_bit_serializer, owns the shift register, phase counter and ready-gated clock generation. It takes load/byte in and returns byte_done. The FSM and arbiter stay in the top level.

Test Plan:
- CLK_DIV=2, req0 with cmd0=2, ready=1 -> transfer_data bits 0,0,0,0,0,0,1,0 on 8 rising edges, 4 clk apart; done 34 clk after grant; grant=01.
- req1 with cmd1=7, pay_data1 returns a counter 0..127 -> exactly 128 pay_rd pulses; 1032 rising edges; station sees bytes 7,0,1..127; single done.
- req=11 from IDLE, cmd0=1, cmd1=3 -> requester 0 served then requester 1; repeat tie -> requester 0 again; grant never both bits.
- ready forced low for 20 clk at the end of bit 3's low phase -> transfer_clock stays low for those 20 clk, no lost or duplicated bit, byte still correct.
- cmd0=5 -> err pulse, zero transfer_clock edges, GAP_CYCLES idle, then next request served.
- rst asserted mid-payload (byte 40) -> outputs 0 immediately (async); after release, IDLE; a fresh cmd 4 transfers correctly.
